tft_timing_gen: RTL and testbench

- Pixel-clock-domain timing controller for the parallel RGB TFT panel.
- Runs on the TFT pixel clock and the lock indication from the system PLL.
- Generates HSYNC/VSYNC/DE and pixel coordinates, pulls RGB pixels from the upstream line FIFO over a ready/valid handshake, and drives the panel pins with registered outputs.
- Holds the panel idle until the PLL has been locked and stable.

---
 rtl/tft_timing_gen.sv | 178 +++++++++++++++++
 tb/tb_tft_timing_gen.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tft_timing_gen.sv
// Pixel-clock timing generator for a parallel RGB TFT panel.
// Generates HSYNC/VSYNC/DE and frame-start from free-running pixel/line counters.
// Pulls pixels from the upstream line FIFO over a ready/valid handshake.
// All panel pins come from one register stage.
// The panel is held idle until the PLL lock has been stable for LOCK_WAIT clocks.
module tft_timing_gen #(
  parameter int unsigned H_ACTIVE  = 480,
  parameter int unsigned H_FP      = 2,
  parameter int unsigned H_SYNC    = 41,
  parameter int unsigned H_BP      = 2,
  parameter int unsigned V_ACTIVE  = 272,
  parameter int unsigned V_FP      = 2,
  parameter int unsigned V_SYNC    = 10,
  parameter int unsigned V_BP      = 2,
  parameter int unsigned LOCK_WAIT = 1024,
  parameter int unsigned RGB_W     = 24
) (
  input  logic             clkTFT10,
  input  logic             sysRst_n,
  input  logic             locked,
  input  logic             enable,
  input  logic [RGB_W-1:0] pixData,
  input  logic             pixValid,
  output logic             pixReady,
  output logic             tftHsync,
  output logic             tftVsync,
  output logic             tftDe,
  output logic [RGB_W-1:0] tftRgb,
  output logic             frameStart,
  output logic             underflow,
  input  logic             underflowClr,
  output logic             running
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned LCW     = $clog2(LOCK_WAIT + 1);

  localparam logic [HW-1:0]  H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]  V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_WAIT - 1);

  // Region bounds kept as 32-bit values so H_BP/V_BP = 0 cannot overflow the counter width.
  localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned HS_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned VS_END = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_d;
  logic [HW-1:0]    r_hcnt;
  logic [HW-1:0]    w_hcnt_d;
  logic [VW-1:0]    r_vcnt;
  logic [VW-1:0]    w_vcnt_d;
  logic [LCW-1:0]   r_lock_cnt;
  logic             r_lock_meta;
  logic             r_lock_sync;

  logic             r_hsync;
  logic             r_vsync;
  logic             r_de;
  logic [RGB_W-1:0] r_rgb;
  logic             r_frame_start;
  logic             r_underflow;

  logic             w_run;
  logic             w_act;
  logic             w_hs;
  logic             w_vs;
  logic             w_lock_done;
  logic             w_frame_end;

  assign w_run       = (r_state == ST_RUN);
  assign w_act       = (32'(r_hcnt) < H_ACTIVE) && (32'(r_vcnt) < V_ACTIVE);
  assign w_hs        = (32'(r_hcnt) >= HS_BEG) && (32'(r_hcnt) < HS_END);
  assign w_vs        = (32'(r_vcnt) >= VS_BEG) && (32'(r_vcnt) < VS_END);
  assign w_lock_done = r_lock_sync && (r_lock_cnt == LOCK_LAST);
  assign w_frame_end = (r_hcnt == H_LAST) && (r_vcnt == V_LAST);

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clkTFT10 or negedge sysRst_n) begin
    if (!sysRst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= locked;
      r_lock_sync <= r_lock_meta;
    end
  end

  // Lock stability counter; saturates so a later enable restarts without a new wait.
  always_ff @(posedge clkTFT10 or negedge sysRst_n) begin
    if (!sysRst_n) begin
      r_lock_cnt <= '0;
    end else if (!r_lock_sync) begin
      r_lock_cnt <= '0;
    end else if (r_lock_cnt != LOCK_LAST) begin
      r_lock_cnt <= r_lock_cnt + LCW'(1);
    end
  end

  // Next-state and counter logic: frames always complete unless lock is lost.
  always_comb begin
    w_state_d = r_state;
    w_hcnt_d  = '0;
    w_vcnt_d  = '0;
    if (r_state == ST_RUN) begin
      if (!r_lock_sync) begin
        w_state_d = ST_IDLE;
      end else if (w_frame_end && !enable) begin
        w_state_d = ST_IDLE;
      end else if (r_hcnt == H_LAST) begin
        w_vcnt_d = (r_vcnt == V_LAST) ? '0 : r_vcnt + VW'(1);
      end else begin
        w_hcnt_d = r_hcnt + HW'(1);
        w_vcnt_d = r_vcnt;
      end
    end else if (w_lock_done && enable) begin
      w_state_d = ST_RUN;
    end
  end

  // State and counter registers.
  always_ff @(posedge clkTFT10 or negedge sysRst_n) begin
    if (!sysRst_n) begin
      r_state <= ST_IDLE;
      r_hcnt  <= '0;
      r_vcnt  <= '0;
    end else begin
      r_state <= w_state_d;
      r_hcnt  <= w_hcnt_d;
      r_vcnt  <= w_vcnt_d;
    end
  end

  // Panel output stage: one cycle behind the counters, forced idle outside RUN.
  always_ff @(posedge clkTFT10 or negedge sysRst_n) begin
    if (!sysRst_n) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_de          <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= ~(w_run && w_hs);
      r_vsync       <= ~(w_run && w_vs);
      r_de          <= w_run && w_act;
      r_rgb         <= (w_run && w_act && pixValid) ? pixData : '0;
      r_frame_start <= w_run && (r_hcnt == '0) && (r_vcnt == '0);
    end
  end

  // Sticky underflow flag; a new miss beats a simultaneous clear.
  always_ff @(posedge clkTFT10 or negedge sysRst_n) begin
    if (!sysRst_n) begin
      r_underflow <= 1'b0;
    end else if (w_run && w_act && !pixValid) begin
      r_underflow <= 1'b1;
    end else if (underflowClr) begin
      r_underflow <= 1'b0;
    end
  end

  assign pixReady   = w_run && w_act;
  assign tftHsync   = r_hsync;
  assign tftVsync   = r_vsync;
  assign tftDe      = r_de;
  assign tftRgb     = r_rgb;
  assign frameStart = r_frame_start;
  assign underflow  = r_underflow;
  assign running    = w_run;

endmodule

// File: tb/tb_tft_timing_gen.sv
// Self-checking bench for tft_timing_gen using a reduced panel geometry.
module tb_tft_timing_gen;

  localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int unsigned VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int unsigned LW = 16, RW = 24;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          locked;
  logic          enable;
  logic [RW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [RW-1:0] rgb;
  logic          frame_start;
  logic          underflow;
  logic          underflow_clr;
  logic          running;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected panel pixel pushed at each request, consumed on each DE cycle.
  logic [RW-1:0] exp_q[$];
  int rd_idx   = 0;
  int acc_cnt  = 0;
  int acc_last = 0;

  tft_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .LOCK_WAIT(LW), .RGB_W(RW)
  ) dut (
    .clkTFT10    (clk),
    .sysRst_n    (rst_n),
    .locked      (locked),
    .enable      (enable),
    .pixData     (pix_data),
    .pixValid    (pix_valid),
    .pixReady    (pix_ready),
    .tftHsync    (hsync),
    .tftVsync    (vsync),
    .tftDe       (de),
    .tftRgb      (rgb),
    .frameStart  (frame_start),
    .underflow   (underflow),
    .underflowClr(underflow_clr),
    .running     (running)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pix_ready) begin
      exp_q.push_back(pix_valid ? pix_data : '0);
      if (pix_valid) acc_cnt = acc_cnt + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance one clock; move to the next data word once the current one was accepted.
  task automatic tick();
    @(posedge clk);
    #1;
    if (acc_cnt != acc_last) begin
      pix_data = pix_data + 1;
      acc_last = acc_cnt;
    end
  endtask

  task automatic wait_frame_start(output bit ok);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < 3 * FRAME);
    ok = frame_start;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; locked = 1'b0; enable = 1'b0;
    pix_valid = 1'b1; pix_data = 24'h000001; underflow_clr = 1'b0;
    repeat (3) tick();
    checks++;
    if ({hsync, vsync, de, frame_start, pix_ready, underflow, running} !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 1100000",
               {hsync, vsync, de, frame_start, pix_ready, underflow, running});
    end
    checks++;
    if (rgb !== '0) begin errors++; $display("FAIL reset_rgb: got %h want 0", rgb); end
  endtask

  task automatic test_lock_start();
    int n;
    rst_n = 1'b1; enable = 1'b1;
    repeat (4) tick();
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL no_lock_idle: got %b want 0", running); end
    locked = 1'b1;
    n = 0;
    while (running !== 1'b1 && n < 200) begin tick(); n++; end
    checks++;
    if (n != LW + 2) begin errors++; $display("FAIL lock_latency: got %0d want %0d", n, LW + 2); end
    checks++;
    if (frame_start !== 1'b0) begin
      errors++; $display("FAIL early_frame_start: got %b want 0", frame_start);
    end
    tick();
    checks++;
    if ({frame_start, de} !== 2'b11) begin
      errors++; $display("FAIL first_frame_start: got fs/de %b want 11", {frame_start, de});
    end
  endtask

  // Entered on a frameStart sample; samples one full frame.
  task automatic test_line_timing();
    int de_cnt, hs_cnt, vs_cnt, fs_cnt, first_hs, first_vs, first_fall, acc0;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
    first_hs = -1; first_vs = -1; first_fall = -1;
    acc0 = acc_cnt;
    for (int k = 0; k < int'(FRAME); k++) begin
      if (k > 0) tick();
      if (de) de_cnt++;
      if (!de && first_fall < 0) first_fall = k;
      if (!hsync) begin hs_cnt++; if (first_hs < 0) first_hs = k; end
      if (!vsync) begin vs_cnt++; if (first_vs < 0) first_vs = k; end
      if (frame_start) fs_cnt++;
    end
    tick();
    checks++;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL frame_period: got fs %b want 1", frame_start); end
    checks++;
    if (de_cnt != HA * VA) begin errors++; $display("FAIL de_count: got %0d want %0d", de_cnt, HA * VA); end
    checks++;
    if (first_fall != HA) begin errors++; $display("FAIL de_width: got %0d want %0d", first_fall, HA); end
    checks++;
    if (first_hs != HA + HF) begin errors++; $display("FAIL hs_start: got %0d want %0d", first_hs, HA + HF); end
    checks++;
    if (hs_cnt != HS * VT) begin errors++; $display("FAIL hs_count: got %0d want %0d", hs_cnt, HS * VT); end
    checks++;
    if (first_vs != (VA + VF) * HT) begin
      errors++; $display("FAIL vs_start: got %0d want %0d", first_vs, (VA + VF) * HT);
    end
    checks++;
    if (vs_cnt != VS * HT) begin errors++; $display("FAIL vs_count: got %0d want %0d", vs_cnt, VS * HT); end
    checks++;
    if (fs_cnt != 1) begin errors++; $display("FAIL fs_count: got %0d want 1", fs_cnt); end
    checks++;
    if (acc_cnt - acc0 != HA * VA) begin
      errors++; $display("FAIL accept_count: got %0d want %0d", acc_cnt - acc0, HA * VA);
    end
  endtask

  task automatic test_data_path();
    rd_idx = exp_q.size();
    for (int k = 0; k < int'(FRAME + HT); k++) begin
      tick();
      checks++;
      if (de) begin
        if (rd_idx >= exp_q.size()) begin
          errors++; $display("FAIL sb_empty: got DE with no request, rgb %h", rgb);
        end else begin
          if (rgb !== exp_q[rd_idx]) begin
            errors++; $display("FAIL rgb_data: got %h want %h", rgb, exp_q[rd_idx]);
          end
          rd_idx++;
        end
      end else if (rgb !== '0) begin
        errors++; $display("FAIL blank_rgb: got %h want 0", rgb);
      end
    end
    checks++;
    if (rd_idx != exp_q.size()) begin
      errors++; $display("FAIL sb_drain: got %0d consumed want %0d", rd_idx, exp_q.size());
    end
  endtask

  task automatic test_underflow();
    bit ok;
    int n;
    wait_frame_start(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL uf_wait_fs: got timeout want frameStart"); end
    rd_idx = exp_q.size();
    pix_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({de, underflow} !== 2'b11 || rgb !== '0 || rgb !== exp_q[rd_idx]) begin
        errors++; $display("FAIL uf_gap: got de/uf %b rgb %h want 11 rgb 0", {de, underflow}, rgb);
      end
      rd_idx++;
    end
    pix_valid = 1'b1;
    repeat (5) tick();
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b want 1", underflow); end
    underflow_clr = 1'b1; tick(); underflow_clr = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b want 0", underflow); end
    n = 0;
    while (!pix_ready && n < int'(FRAME)) begin tick(); n++; end
    pix_valid = 1'b0; underflow_clr = 1'b1;
    tick();
    pix_valid = 1'b1; underflow_clr = 1'b0;
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set_wins: got %b want 1", underflow); end
    underflow_clr = 1'b1; tick(); underflow_clr = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear2: got %b want 0", underflow); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int n;
    wait_frame_start(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL en_wait_fs: got timeout want frameStart"); end
    n = 0;
    while (running && n < 3 * int'(FRAME)) begin
      tick();
      n++;
      if (n == 2 * int'(HT)) enable = 1'b0;
    end
    checks++;
    if (n != FRAME - 1) begin errors++; $display("FAIL en_frame_done: got %0d want %0d", n, FRAME - 1); end
    tick();
    checks++;
    if ({hsync, vsync, de, frame_start, pix_ready, running} !== 6'b110000 || rgb !== '0) begin
      errors++; $display("FAIL en_idle_out: got %b rgb %h want 110000 rgb 0",
                         {hsync, vsync, de, frame_start, pix_ready, running}, rgb);
    end
    repeat (3) tick();
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL en_stay_idle: got %b want 0", running); end
    enable = 1'b1;
    tick();
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL en_restart: got %b want 1", running); end
    tick();
    checks++;
    if ({frame_start, de} !== 2'b11) begin
      errors++; $display("FAIL en_restart_fs: got %b want 11", {frame_start, de});
    end
  endtask

  task automatic test_lock_loss();
    int n;
    repeat (2 * HT + 5) tick();
    locked = 1'b0;
    n = 0;
    while (running && n < 20) begin tick(); n++; end
    checks++;
    if (n != 3) begin errors++; $display("FAIL ll_latency: got %0d want 3", n); end
    tick();
    checks++;
    if ({hsync, vsync, de, pix_ready} !== 4'b1100 || rgb !== '0) begin
      errors++; $display("FAIL ll_idle_out: got %b rgb %h want 1100 rgb 0",
                         {hsync, vsync, de, pix_ready}, rgb);
    end
    locked = 1'b1;
    n = 0;
    while (!running && n < 200) begin tick(); n++; end
    checks++;
    if (n != LW + 2) begin errors++; $display("FAIL ll_relock: got %0d want %0d", n, LW + 2); end
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    while (!pix_ready && n < int'(FRAME)) begin tick(); n++; end
    pix_valid = 1'b0; tick(); pix_valid = 1'b1;
    checks++;
    if ({de, underflow} !== 2'b11) begin
      errors++; $display("FAIL ar_pre: got de/uf %b want 11", {de, underflow});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hsync, vsync, de, frame_start, pix_ready, underflow, running} !== 7'b1100000 ||
        rgb !== '0) begin
      errors++; $display("FAIL ar_outputs: got %b rgb %h want 1100000 rgb 0",
                         {hsync, vsync, de, frame_start, pix_ready, underflow, running}, rgb);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_lock_start();
    test_line_timing();
    test_data_path();
    test_underflow();
    test_enable_drop();
    test_lock_loss();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
